// File: rtl/ipq_pkg.sv
// rtl/ipq_pkg.sv - shared types and constants for the instruction prefetch queue
package ipq_pkg;

  localparam int IPQ_DATA_W  = 32;
  localparam int IPQ_ADDR_W  = 32;
  localparam int INSTR_BYTES = 4;

  // WAIT: one request granted, response pending.
  // DRAIN: the pending response belongs to a flushed stream and is dropped.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } ipq_state_t;

  typedef struct packed {
    logic [IPQ_DATA_W-1:0] instr;
    logic [IPQ_ADDR_W-1:0] pc;
  } ipq_entry_t;

endpackage

// File: rtl/ipq_fifo.sv
// rtl/ipq_fifo.sv - circular buffer of fetched instruction/PC entries
module ipq_fifo
  import ipq_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          push,
  input  ipq_entry_t    push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output ipq_entry_t    head
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  ipq_entry_t  mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign count = CW'(wr_ptr - rd_ptr);
  assign head  = mem[rd_ptr[PW-1:0]];

  // Pointer update; flush discards every entry at once.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Entry storage; contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (push && !full && !flush) begin
      mem[wr_ptr[PW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - autonomous instruction prefetcher with redirect and flush
module instr_prefetch_queue
  import ipq_pkg::*;
#(
  parameter int                DATA_W   = IPQ_DATA_W,
  parameter int                ADDR_W   = IPQ_ADDR_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int               CW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic [CW-1:0]     count
);

  ipq_state_t        state;
  ipq_state_t        state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] issued_pc;
  logic [ADDR_W-1:0] redirect_pc_al;
  logic              issue;
  logic              push;
  logic              pop;
  logic [CW-1:0]     q_count;
  logic              q_empty;
  logic              q_full;
  ipq_entry_t        push_entry;
  ipq_entry_t        head;
  logic [CW:0]       count_after_push;
  logic              space_now;
  logic              space_after_push;

  assign redirect_pc_al = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign imem_addr      = {fetch_pc[ADDR_W-1:2], 2'b00};

  // A redirect wins over both queue operations in its cycle.
  assign issue = (state == REQ) && imem_gnt;
  assign push  = (state == WAIT) && imem_rvalid && !redirect_valid;
  assign pop   = !q_empty && instr_ready && !redirect_valid;

  // Only one request is ever outstanding, so a slot must be free once the
  // current response lands before the next request may be presented.
  assign count_after_push = {1'b0, q_count} + (CW + 1)'(1) - (CW + 1)'(pop);
  assign space_after_push = count_after_push < (CW + 1)'(DEPTH);
  assign space_now        = q_count < CW'(DEPTH);

  assign push_entry.instr = imem_rdata;
  assign push_entry.pc    = issued_pc;

  ipq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full),
    .head      (head)
  );

  assign instr_valid = !q_empty;
  assign instr       = instr_valid ? head.instr : '0;
  assign instr_pc    = instr_valid ? head.pc : '0;
  assign count       = q_count;

  // Fetch state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and request strobe; a redirect decides whether a response is still owed.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      IDLE: begin
        if (space_now) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_nxt = space_after_push ? REQ : IDLE;
        end
      end
      DRAIN: begin
        if (imem_rvalid) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect_valid) begin
      case (state)
        REQ:         state_nxt = imem_gnt ? DRAIN : REQ;
        WAIT, DRAIN: state_nxt = imem_rvalid ? REQ : DRAIN;
        default:     state_nxt = REQ;
      endcase
    end
  end

  // Next fetch address; the PC of a granted request is held for its response.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fetch_pc  <= RESET_PC;
      issued_pc <= '0;
    end else begin
      if (issue) begin
        issued_pc <= imem_addr;
      end
      if (redirect_valid) begin
        fetch_pc <= redirect_pc_al;
      end else if (issue) begin
        fetch_pc <= imem_addr + ADDR_W'(INSTR_BYTES);
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb/tb_instr_prefetch_queue.sv - randomized self-checking bench for instr_prefetch_queue
module tb_instr_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          CW       = $clog2(DEPTH + 1);
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic          instr_ready = 1'b0;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  instr_prefetch_queue #(
    .DATA_W   (32),
    .ADDR_W   (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .nrst           (nrst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .count          (count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the architectural queue contents and the fetch stream.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_fetch;
  bit          m_inflight;
  bit          m_stale;
  logic [31:0] m_inflight_pc;
  logic [31:0] pop_log[$];
  logic [31:0] gnt_log[$];
  bit          saw_beef = 1'b0;

  // Memory responder state and stimulus knobs.
  bit          mem_busy = 1'b0;
  int          mem_lat  = 0;
  logic [31:0] mem_addr_q;
  int          gnt_pct   = 100;
  int          lat_max   = 1;
  int          lat_fixed = -1;
  int          ready_pct = 0;
  int          redir_pct = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h3e800093;
      32'h4:   return 32'h83000113;
      32'h8:   return 32'h3e906193;
      32'hc:   return 32'h45707213;
      default: return (a * 32'h9E3779B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_fetch    = RESET_PC;
    m_inflight = 1'b0;
    m_stale    = 1'b0;
  endtask

  task automatic choose_inputs();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_busy) begin
      if (mem_lat == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = m_stale ? 32'hdeadbeef : mem_word(mem_addr_q);
      end else begin
        mem_lat--;
      end
    end else if (imem_req && ($urandom_range(99) < gnt_pct)) begin
      imem_gnt = 1'b1;
    end
    instr_ready    = ($urandom_range(99) < ready_pct);
    redirect_valid = ($urandom_range(99) < redir_pct);
    redirect_pc    = $urandom;
  endtask

  task automatic cycle();
    bit   do_pop;
    ent_t e;
    check("addr_align", imem_addr[1:0], 2'b00);
    if (imem_req) check("space_rule", (m_q.size() + int'(m_inflight)) < DEPTH, 1'b1);
    do_pop = !redirect_valid && (m_q.size() > 0) && instr_ready;
    if (imem_rvalid) mem_busy = 1'b0;
    if (imem_rvalid && m_inflight) begin
      if (!m_stale && !redirect_valid) begin
        e.instr = imem_rdata;
        e.pc    = m_inflight_pc;
        m_q.push_back(e);
      end
      m_inflight = 1'b0;
    end
    if (do_pop) begin
      pop_log.push_back(m_q[0].pc);
      void'(m_q.pop_front());
    end
    if (imem_req && imem_gnt) begin
      check("fetch_addr", imem_addr, m_fetch);
      gnt_log.push_back(imem_addr);
      m_fetch       = m_fetch + 32'd4;
      m_inflight    = 1'b1;
      m_stale       = 1'b0;
      m_inflight_pc = imem_addr;
      mem_busy      = 1'b1;
      mem_addr_q    = imem_addr;
      mem_lat       = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(lat_max - 1));
    end
    if (redirect_valid) begin
      m_q.delete();
      m_fetch = {redirect_pc[31:2], 2'b00};
      if (m_inflight) m_stale = 1'b1;
    end
    @(posedge clk);
    #1;
    check("count", count, m_q.size());
    check("instr_valid", instr_valid, m_q.size() != 0);
    if (m_q.size() > 0) begin
      check("instr", instr, m_q[0].instr);
      check("instr_pc", instr_pc, m_q[0].pc);
    end
    if (instr_valid && instr == 32'hdeadbeef) saw_beef = 1'b1;
    choose_inputs();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"}, imem_req, 1'b0);
    check({tag, "_addr"}, imem_addr, RESET_PC);
    check({tag, "_valid"}, instr_valid, 1'b0);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_pc"}, instr_pc, 32'h0);
    check({tag, "_count"}, count, 0);
  endtask

  initial begin
    bit found;

    #2;
    check_reset_values("reset");
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    model_reset();
    choose_inputs();

    // Fill with the consumer stalled.
    repeat (20) cycle();
    check("fill_count", count, 4);
    check("fill_req", imem_req, 1'b0);
    check("fill_head", instr, 32'h3e800093);
    check("fill_head_pc", instr_pc, 32'h0);

    // Drain with the consumer always ready.
    ready_pct = 100;
    repeat (40) cycle();
    check("drain_rate", pop_log.size() >= 18, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (pop_log.size() > i) check("drain_order", pop_log[i], 32'(4 * i));
    end

    // Redirect while a response is pending.
    ready_pct = 50;
    lat_fixed = 2;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (mem_busy && !imem_rvalid) found = 1'b1;
      else cycle();
    end
    check("wait_found", found, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cycle();
    check("redir_count", count, 0);
    check("redir_valid", instr_valid, 1'b0);
    gnt_log.delete();
    for (int i = 0; i < 50 && gnt_log.size() == 0; i++) cycle();
    check("redir_gnt_seen", gnt_log.size() > 0, 1'b1);
    if (gnt_log.size() > 0) check("redir_addr", gnt_log[0], 32'h100);

    // Redirect coinciding with a pop and a push.
    ready_pct = 0;
    lat_fixed = 0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (imem_rvalid && instr_valid) found = 1'b1;
      else cycle();
    end
    check("collide_found", found, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    instr_ready    = 1'b1;
    cycle();
    check("collide_count", count, 0);
    check("collide_valid", instr_valid, 1'b0);

    // Address wrap at the top of the space.
    ready_pct = 100;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    cycle();
    gnt_log.delete();
    for (int i = 0; i < 50 && gnt_log.size() < 2; i++) cycle();
    check("wrap_gnts", gnt_log.size() >= 2, 1'b1);
    if (gnt_log.size() >= 2) begin
      check("wrap_first", gnt_log[0], 32'hFFFF_FFFC);
      check("wrap_second", gnt_log[1], 32'h0);
    end

    // Asynchronous reset with two entries queued and a response pending.
    ready_pct = 0;
    lat_fixed = 2;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    cycle();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_q.size() == 2 && mem_busy && !imem_rvalid) found = 1'b1;
      else cycle();
    end
    check("areset_setup", found, 1'b1);
    #2;
    nrst = 1'b0;
    #1;
    check_reset_values("areset");
    model_reset();
    @(posedge clk);
    #1;
    nrst           = 1'b1;
    mem_busy       = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'hdeadbeef;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    cycle();
    gnt_log.delete();
    for (int i = 0; i < 50 && gnt_log.size() == 0; i++) cycle();
    check("areset_gnt_seen", gnt_log.size() > 0, 1'b1);
    if (gnt_log.size() > 0) check("areset_addr", gnt_log[0], RESET_PC);

    // Randomized traffic with occasional redirects.
    gnt_pct   = 60;
    lat_fixed = -1;
    lat_max   = 3;
    ready_pct = 60;
    redir_pct = 4;
    repeat (3000) cycle();

    check("no_stale_data", saw_beef, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
Parametrised instruction prefetch queue between instruction memory and the single-cycle core's decode stage.
Generalises the current one-instruction-per-cycle direct drive of the core's instruction input: it fetches autonomously from a PC, buffers DEPTH instructions with their PCs, and presents them over a valid/ready handshake.
Supports redirect (branch/jump) with flush, and discards a stale in-flight response after a redirect.

Parameters:
DATA_W, 32, instruction width in bits
ADDR_W, 32, PC/address width in bits
DEPTH, 4, queue entries (power of two, >=2)
RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
clk  in  1  clock, rising edge
nrst  in  1  asynchronous active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_W  fetch address, word aligned
imem_gnt  in  1  memory accepts request this cycle (req & gnt = issued)
imem_rvalid  in  1  response data valid
imem_rdata  in  DATA_W  response instruction
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  ADDR_W  new fetch address
instr_valid  out  1  head entry valid
instr  out  DATA_W  head instruction
instr_pc  out  ADDR_W  PC of head instruction
instr_ready  in  1  consumer takes head when valid & ready
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (async, nrst=0): imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, count=0, fetch_pc=RESET_PC, FSM=IDLE, queue pointers=0.
- One outstanding request at most. Response returns >=1 cycle after grant.
- FSM states:
  - IDLE: imem_req=0. Go to REQ when count + outstanding < DEPTH.
  - REQ: imem_req=1, imem_addr=fetch_pc. On gnt, fetch_pc += 4 (modulo 2^ADDR_W, wraps to 0) and go to WAIT.
  - WAIT: imem_req=0. On rvalid, push {imem_rdata, PC of the issued request}, then go to REQ if space remains, else IDLE.
  - DRAIN: entered when a redirect occurs in WAIT. The next rvalid is discarded, not pushed, then go to REQ.
- Space rule: a request is issued only if a slot is reserved, so a response never finds the queue full. Overflow is impossible by construction.
- Redirect, registered on the clock edge:
  - Queue empties, count=0, instr_valid=0 the next cycle.
  - fetch_pc=redirect_pc, FSM goes to REQ (or DRAIN if in WAIT).
  - If in REQ with gnt in the same cycle, the granted request counts as stale and FSM goes to DRAIN.
- Redirect takes priority over a pop and a push in the same cycle. Neither takes effect.
- Push and pop in the same cycle: count unchanged, pointers both advance.
- No bypass: a response at edge N sets instr_valid at the cycle after edge N. Minimum rvalid-to-instr_valid latency is 1 cycle.
- Output registers: instr, instr_pc, instr_valid reflect the head entry and are stable while instr_valid & !instr_ready.
- Empty: instr_valid=0, and instr_ready is ignored.
- Full (count==DEPTH): no new request until a pop.
- imem_addr[1:0] is always 0. redirect_pc[1:0] is forced to 0.
- nrst asserted mid-transaction: immediate return to reset values. A late response after reset is ignored because FSM=IDLE on the first cycle.

Decomposition:
- Package ipq_pkg holds:
  - typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} ipq_state_t
  - localparam INSTR_BYTES = 4
  - packed struct ipq_entry_t {instr, pc}, parametrised through package params or macros
- One sub-module: ipq_fifo, a synchronous circular buffer of ipq_entry_t.
  - Ports: push/pop/flush, count, head out.
  - Pointers one bit wider than log2(DEPTH) for the full/empty test.

Test Plan:
- Reset then fill: memory returns 32'h3e800093, 32'h83000113, 32'h3e906193, 32'h45707213 for PCs 0,4,8,12 with 1-cycle gnt/rvalid; instr_ready=0 -> count reaches 4, imem_req stays 0, head = 32'h3e800093 at pc 0.
- Drain with instr_ready=1 held -> instructions emerge in order with instr_pc 0,4,8,12,16...; sustained throughput limited by 2-cycle fetch round trip; count never exceeds DEPTH.
- Redirect to 32'h100 while in WAIT -> queue empties next cycle; stale rvalid data 32'hdeadbeef never appears at instr; next issued imem_addr=32'h100.
- Redirect with simultaneous instr_ready and rvalid -> no pop counted, no push, count=0, instr_valid=0.
- Wrap: redirect_pc=32'hFFFF_FFFC -> fetched PCs FFFF_FFFC then 0000_0000.
- Async reset asserted mid-WAIT with 2 entries queued -> all outputs at reset values immediately; following rvalid ignored; first request after release is at RESET_PC.
